// File: rtl/regfile_mp_stage.sv
// Multi-port register-read stage: NUM_CH issue channels read two operands each, NUM_WB writebacks with bypass.
// Optional pending-bit scoreboard for out_src_rdy enabled by defining SCOREBOARD_EN.
module regfile_mp_stage #(
  parameter int NUM_CH   = 4,
  parameter int NUM_WB   = 4,
  parameter int NUM_REGS = 16,
  parameter int DATA_W   = 32,
  parameter int OP_W     = 4,
  parameter int BID_W    = 3,
  parameter int IMM_W    = 5,
  localparam int RIW     = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [NUM_CH-1:0]        in_vld,
  input  logic [NUM_CH*RIW-1:0]    in_des,
  input  logic [NUM_CH*RIW-1:0]    in_s1,
  input  logic [NUM_CH*RIW-1:0]    in_s2,
  input  logic [NUM_CH*OP_W-1:0]   in_op,
  input  logic [NUM_CH*BID_W-1:0]  in_branch,
  input  logic [NUM_CH*IMM_W-1:0]  in_ime,
  output logic                     in_ready,
  input  logic [NUM_WB-1:0]        wb_vld,
  input  logic [NUM_WB*RIW-1:0]    wb_des,
  input  logic [NUM_WB*DATA_W-1:0] wb_data,
  input  logic                     out_ready,
  output logic [NUM_CH-1:0]        out_vld,
  output logic [NUM_CH*RIW-1:0]    out_des,
  output logic [NUM_CH*OP_W-1:0]   out_op,
  output logic [NUM_CH*BID_W-1:0]  out_branch,
  output logic [NUM_CH*IMM_W-1:0]  out_ime,
  output logic [NUM_CH*DATA_W-1:0] out_s1_data,
  output logic [NUM_CH*DATA_W-1:0] out_s2_data,
  output logic [2*NUM_CH-1:0]      out_src_rdy
);
  localparam int NSRC = 2*NUM_CH;

  logic [DATA_W-1:0]        r_rf [NUM_REGS];
  logic [NUM_CH-1:0]        r_vld;
  logic [NUM_CH*RIW-1:0]    r_des;
  logic [NUM_CH*OP_W-1:0]   r_op;
  logic [NUM_CH*BID_W-1:0]  r_branch;
  logic [NUM_CH*IMM_W-1:0]  r_ime;
  logic [DATA_W-1:0]        r_opnd    [NSRC];
  logic [RIW-1:0]           r_src_idx [NSRC];
  logic                     w_ready;

  // Returns {hit, data}; scanning high to low lets the lowest matching port win.
  function automatic logic [DATA_W:0] wb_fwd(input logic [RIW-1:0] idx,
                                             input logic [NUM_WB-1:0] v,
                                             input logic [NUM_WB*RIW-1:0] d,
                                             input logic [NUM_WB*DATA_W-1:0] x);
    logic [DATA_W:0] res;
    res = '0;
    for (int w = NUM_WB-1; w >= 0; w--)
      if (v[w] && idx != '0 && d[w*RIW +: RIW] == idx) res = {1'b1, x[w*DATA_W +: DATA_W]};
    return res;
  endfunction

  assign w_ready  = out_ready | ~|r_vld;
  assign in_ready = w_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) r_rf[i] <= '0;
    end else begin
      for (int w = NUM_WB-1; w >= 0; w--)
        if (wb_vld[w] && wb_des[w*RIW +: RIW] != '0)
          r_rf[wb_des[w*RIW +: RIW]] <= wb_data[w*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld    <= '0;
      r_des    <= '0;
      r_op     <= '0;
      r_branch <= '0;
      r_ime    <= '0;
    end else begin
      if (flush)        r_vld <= '0;
      else if (w_ready) r_vld <= in_vld;
      if (w_ready) begin
        r_des    <= in_des;
        r_op     <= in_op;
        r_branch <= in_branch;
        r_ime    <= in_ime;
      end
    end
  end

`ifdef SCOREBOARD_EN
  logic [NUM_REGS-1:0] r_pend;
  logic [NUM_REGS-1:0] w_clr, w_set, w_pend_clr;
  logic [NSRC-1:0]     r_rdy;

  always_comb begin
    w_clr = '0;
    w_set = '0;
    for (int w = 0; w < NUM_WB; w++)
      if (wb_vld[w]) w_clr[wb_des[w*RIW +: RIW]] = 1'b1;
    // A discarded (flushed) group must not mark its destinations busy.
    if (w_ready && !flush)
      for (int c = 0; c < NUM_CH; c++)
        if (in_vld[c] && in_des[c*RIW +: RIW] != '0) w_set[in_des[c*RIW +: RIW]] = 1'b1;
    w_pend_clr = r_pend & ~w_clr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_pend <= '0;
    else     r_pend <= w_pend_clr | w_set;
  end

  assign out_src_rdy = r_rdy;
`else
  assign out_src_rdy = '1;
`endif

  for (genvar k = 0; k < NSRC; k++) begin : g_src
    localparam int C = k/2;
    logic [RIW-1:0]    w_idx;
    logic [DATA_W:0]   w_in_fwd, w_hd_fwd;
    logic [DATA_W-1:0] w_rd;

    assign w_idx    = (k % 2 == 1) ? in_s2[C*RIW +: RIW] : in_s1[C*RIW +: RIW];
    assign w_in_fwd = wb_fwd(w_idx, wb_vld, wb_des, wb_data);
    assign w_hd_fwd = wb_fwd(r_src_idx[k], wb_vld, wb_des, wb_data);
    assign w_rd     = (w_idx == '0) ? '0 :
                      w_in_fwd[DATA_W] ? w_in_fwd[DATA_W-1:0] : r_rf[w_idx];

    // Held operands keep tracking writebacks so execute never sees a stale value.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_opnd[k]    <= '0;
        r_src_idx[k] <= '0;
      end else if (w_ready) begin
        r_opnd[k]    <= w_rd;
        r_src_idx[k] <= w_idx;
      end else if (w_hd_fwd[DATA_W]) begin
        r_opnd[k]    <= w_hd_fwd[DATA_W-1:0];
      end
    end

`ifdef SCOREBOARD_EN
    logic w_older;
    always_comb begin
      w_older = 1'b0;
      for (int j = 0; j < C; j++)
        if (in_vld[j] && in_des[j*RIW +: RIW] == w_idx) w_older = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst)                   r_rdy[k] <= 1'b1;
      else if (w_ready)          r_rdy[k] <= (w_idx == '0) | (~w_pend_clr[w_idx] & ~w_older);
      else if (w_hd_fwd[DATA_W]) r_rdy[k] <= 1'b1;
    end
`endif

    if (k % 2 == 1) begin : g_s2
      assign out_s2_data[C*DATA_W +: DATA_W] = r_opnd[k];
    end else begin : g_s1
      assign out_s1_data[C*DATA_W +: DATA_W] = r_opnd[k];
    end
  end

  assign out_vld    = r_vld;
  assign out_des    = r_des;
  assign out_op     = r_op;
  assign out_branch = r_branch;
  assign out_ime    = r_ime;
endmodule

// File: tb/tb_regfile_mp_stage.sv
// Directed bench for regfile_mp_stage: reference model pushes expected groups to a queue, popped on each load.
module tb_regfile_mp_stage;
  localparam int CH = 4, WB = 4, NR = 16, DW = 32, RW = 4, OW = 4, BW = 3, IW = 5;

  logic clk = 1'b0, rst = 1'b1, flush = 1'b0;
  logic [CH-1:0]    in_vld = '0;
  logic [CH*RW-1:0] in_des = '0, in_s1 = '0, in_s2 = '0;
  logic [CH*OW-1:0] in_op = '0;
  logic [CH*BW-1:0] in_branch = '0;
  logic [CH*IW-1:0] in_ime = '0;
  logic             in_ready;
  logic [WB-1:0]    wb_vld = '0;
  logic [WB*RW-1:0] wb_des = '0;
  logic [WB*DW-1:0] wb_data = '0;
  logic             out_ready = 1'b1;
  logic [CH-1:0]    out_vld;
  logic [CH*RW-1:0] out_des;
  logic [CH*OW-1:0] out_op;
  logic [CH*BW-1:0] out_branch;
  logic [CH*IW-1:0] out_ime;
  logic [CH*DW-1:0] out_s1_data, out_s2_data;
  logic [2*CH-1:0]  out_src_rdy;

  regfile_mp_stage dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_vld(in_vld), .in_des(in_des), .in_s1(in_s1), .in_s2(in_s2),
    .in_op(in_op), .in_branch(in_branch), .in_ime(in_ime), .in_ready(in_ready),
    .wb_vld(wb_vld), .wb_des(wb_des), .wb_data(wb_data),
    .out_ready(out_ready), .out_vld(out_vld), .out_des(out_des), .out_op(out_op),
    .out_branch(out_branch), .out_ime(out_ime),
    .out_s1_data(out_s1_data), .out_s2_data(out_s2_data), .out_src_rdy(out_src_rdy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CH-1:0]    vld;
    logic [CH*RW-1:0] des, s1, s2;
    logic [CH*OW-1:0] op;
    logic [CH*BW-1:0] br;
    logic [CH*IW-1:0] ime;
    logic [CH*DW-1:0] d1, d2;
    logic [2*CH-1:0]  rdy;
  } grp_t;

  grp_t q[$];
  grp_t cur;
  logic [DW-1:0] rf_m [NR];
  logic [NR-1:0] pend_m;
  logic [CH-1:0] vld_m;
  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW:0] m_fwd(input logic [RW-1:0] idx);
    for (int w = 0; w < WB; w++)
      if (wb_vld[w] && idx != 0 && wb_des[w*RW +: RW] == idx) return {1'b1, wb_data[w*DW +: DW]};
    return '0;
  endfunction

  function automatic logic [DW-1:0] m_rd(input logic [RW-1:0] idx);
    logic [DW:0] f;
    f = m_fwd(idx);
    if (idx == 0) return '0;
    if (f[DW]) return f[DW-1:0];
    return rf_m[idx];
  endfunction

  task automatic cmp();
    chk("out_vld", out_vld, cur.vld);
    chk("out_des", out_des, cur.des);
    chk("out_op", out_op, cur.op);
    chk("out_branch", out_branch, cur.br);
    chk("out_ime", out_ime, cur.ime);
    chk("out_s1_data", out_s1_data, cur.d1);
    chk("out_s2_data", out_s2_data, cur.d2);
    chk("out_src_rdy", out_src_rdy, cur.rdy);
  endtask

  task automatic cyc();
    grp_t g;
    logic ld;
    logic [DW:0] f;
    logic [RW-1:0] idx;
    logic [NR-1:0] clr, set, pclr;
    #1;
    ld = out_ready | ~|vld_m;
    chk("in_ready", in_ready, ld);
    clr = '0; set = '0;
    for (int w = 0; w < WB; w++) if (wb_vld[w]) clr[wb_des[w*RW +: RW]] = 1'b1;
    pclr = pend_m & ~clr;
    if (ld) begin
      g.vld = flush ? '0 : in_vld;
      g.des = in_des; g.s1 = in_s1; g.s2 = in_s2;
      g.op = in_op; g.br = in_branch; g.ime = in_ime;
      g.d1 = '0; g.d2 = '0; g.rdy = '1;
      for (int k = 0; k < 2*CH; k++) begin
        idx = k[0] ? in_s2[(k/2)*RW +: RW] : in_s1[(k/2)*RW +: RW];
        if (k[0]) g.d2[(k/2)*DW +: DW] = m_rd(idx);
        else      g.d1[(k/2)*DW +: DW] = m_rd(idx);
`ifdef SCOREBOARD_EN
        begin
          logic old;
          old = 1'b0;
          for (int j = 0; j < k/2; j++) if (in_vld[j] && in_des[j*RW +: RW] == idx) old = 1'b1;
          g.rdy[k] = (idx == 0) | (~pclr[idx] & ~old);
        end
`endif
      end
      if (!flush)
        for (int c = 0; c < CH; c++)
          if (in_vld[c] && in_des[c*RW +: RW] != 0) set[in_des[c*RW +: RW]] = 1'b1;
      q.push_back(g);
    end else begin
      for (int k = 0; k < 2*CH; k++) begin
        idx = k[0] ? cur.s2[(k/2)*RW +: RW] : cur.s1[(k/2)*RW +: RW];
        f = m_fwd(idx);
        if (f[DW]) begin
          if (k[0]) cur.d2[(k/2)*DW +: DW] = f[DW-1:0];
          else      cur.d1[(k/2)*DW +: DW] = f[DW-1:0];
          cur.rdy[k] = 1'b1;
        end
      end
    end
    pend_m = pclr | set;
    for (int w = WB-1; w >= 0; w--)
      if (wb_vld[w] && wb_des[w*RW +: RW] != 0) rf_m[wb_des[w*RW +: RW]] = wb_data[w*DW +: DW];
    vld_m = flush ? '0 : (ld ? in_vld : vld_m);
    @(posedge clk); #1;
    if (ld) cur = q.pop_front();
    if (flush) cur.vld = '0;
    cmp();
  endtask

  task automatic clr_in();
    in_vld = '0; in_des = '0; in_s1 = '0; in_s2 = '0;
    in_op = '0; in_branch = '0; in_ime = '0;
    wb_vld = '0; wb_des = '0; wb_data = '0;
  endtask

  task automatic set_ch(input int c, input logic [RW-1:0] des, input logic [RW-1:0] s1,
                        input logic [RW-1:0] s2, input logic [OW-1:0] op);
    in_vld[c] = 1'b1;
    in_des[c*RW +: RW] = des; in_s1[c*RW +: RW] = s1; in_s2[c*RW +: RW] = s2;
    in_op[c*OW +: OW] = op;
    in_branch[c*BW +: BW] = BW'(c + 1);
    in_ime[c*IW +: IW] = IW'(op + 3);
  endtask

  task automatic set_wb(input int w, input logic [RW-1:0] des, input logic [DW-1:0] data);
    wb_vld[w] = 1'b1; wb_des[w*RW +: RW] = des; wb_data[w*DW +: DW] = data;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NR; i++) rf_m[i] = '0;
    pend_m = '0; vld_m = '0; q.delete();
    cur = '{default: '0};
    cur.rdy = '1;
  endtask

  initial begin
    model_reset();
    #12;
    chk("rst_out_vld", out_vld, 0);
    chk("rst_src_rdy", out_src_rdy, 8'hFF);
    chk("rst_s1_data", out_s1_data, 0);
    chk("rst_des", out_des, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    clr_in(); set_wb(0, 5, 32'hDEADBEEF); cyc();
    clr_in(); set_ch(0, 1, 5, 0, 3); cyc();
    chk("r5_read", out_s1_data[31:0], 32'hDEADBEEF);
    chk("r0_read", out_s2_data[31:0], 0);
    chk("vld0", out_vld, 4'b0001);

    clr_in(); set_wb(2, 7, 32'h11); set_ch(3, 2, 1, 7, 6); cyc();
    chk("bypass", out_s2_data[127:96], 32'h11);

    clr_in(); set_wb(1, 9, 32'hA); set_wb(3, 9, 32'hB); set_wb(0, 0, 32'hFF);
    set_ch(0, 3, 9, 0, 1); set_ch(1, 4, 0, 0, 2); cyc();
    chk("conflict_bypass", out_s1_data[31:0], 32'hA);
    chk("r0_ignored", out_s1_data[63:32], 0);
    clr_in(); set_ch(0, 3, 9, 0, 1); set_ch(2, 5, 0, 0, 4); cyc();
    chk("conflict_stored", out_s1_data[31:0], 32'hA);

    clr_in(); set_wb(0, 4, 32'h1); cyc();
    clr_in(); for (int c = 0; c < CH; c++) set_ch(c, RW'(c + 10), RW'(c == 1 ? 4 : 0), 0, OW'(c + 1)); cyc();
    chk("stall_pre", out_s1_data[63:32], 32'h1);
    out_ready = 1'b0;
    clr_in(); for (int c = 0; c < CH; c++) set_ch(c, 1, 2, 3, 4'hF); set_wb(0, 4, 32'h22); cyc();
    chk("refresh", out_s1_data[63:32], 32'h22);
    chk("stall_ready", in_ready, 0);
    clr_in(); cyc();
    chk("hold", out_s1_data[63:32], 32'h22);
    out_ready = 1'b1;
    clr_in(); set_ch(0, 8, 4, 5, 7); cyc();
    chk("retire_load", out_s1_data[31:0], 32'h22);

    clr_in(); for (int c = 0; c < CH; c++) set_ch(c, RW'(c + 1), 4, 5, OW'(c)); cyc();
    out_ready = 1'b0;
    clr_in(); cyc();
    flush = 1'b1; cyc();
    chk("flush_stall", out_vld, 0);
    flush = 1'b0;
    clr_in(); set_ch(0, 0, 4, 5, 1); set_ch(1, 0, 7, 9, 2); cyc();
    chk("rf_r4", out_s1_data[31:0], 32'h22);
    chk("rf_r5", out_s2_data[31:0], 32'hDEADBEEF);
    chk("rf_r7", out_s1_data[63:32], 32'h11);
    chk("rf_r9", out_s2_data[63:32], 32'hA);
    out_ready = 1'b1;
    clr_in(); for (int c = 0; c < CH; c++) set_ch(c, 2, 4, 7, 3); flush = 1'b1; cyc();
    chk("flush_load", out_vld, 0);
    flush = 1'b0;

`ifdef SCOREBOARD_EN
    clr_in(); set_ch(0, 6, 0, 0, 1); cyc();
    clr_in(); set_ch(0, 3, 6, 0, 2); set_ch(1, 2, 3, 0, 3); cyc();
    chk("sb_pending", out_src_rdy[0], 0);
    chk("sb_older", out_src_rdy[2], 0);
    out_ready = 1'b0;
    clr_in(); set_wb(1, 6, 32'h66); cyc();
    chk("sb_refresh", out_src_rdy[0], 1);
    out_ready = 1'b1;
    clr_in(); cyc();
`endif

    clr_in(); for (int c = 0; c < CH; c++) set_ch(c, 1, 4, 9, 5); cyc();
    out_ready = 1'b0;
    clr_in(); cyc();
    rst = 1'b1; #1;
    model_reset();
    chk("rst_mid_vld", out_vld, 0);
    chk("rst_mid_s1", out_s1_data, 0);
    chk("rst_mid_rdy", out_src_rdy, 8'hFF);
    rst = 1'b0; out_ready = 1'b1;
    clr_in(); set_ch(0, 1, 4, 9, 5); cyc();
    chk("rst_rf_clear", out_s1_data[31:0], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
